// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - gate FSM state encoding and signed clamp shared by the control loop blocks
package ctrl_pkg;

  localparam int CMD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_P_ON = 2'd1,
    ST_N_ON = 2'd2,
    ST_DEAD = 2'd3
  } gate_state_t;

  // Signed clamp into [lo, hi]; caller guarantees lo <= hi.
  function automatic logic signed [CMD_W-1:0] clamp_s(
    input logic signed [CMD_W-1:0] x,
    input logic signed [CMD_W-1:0] lo,
    input logic signed [CMD_W-1:0] hi
  );
    logic signed [CMD_W-1:0] r;
    r = x;
    if (x < lo) r = lo;
    else if (x > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/deadtime_gen.sv
// rtl/deadtime_gen.sv - complementary gate FSM with DT-cycle dead gap between gate hand-overs
module deadtime_gen
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DT    = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cnt_zero,
  input  logic i_raw,
  output logic o_pwm_p,
  output logic o_pwm_n
);

  localparam logic [CNT_W-1:0] DT_LAST = (DT > 0) ? CNT_W'(DT - 1) : '0;

  gate_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_dt_cnt, w_dt_cnt_nxt;
  logic             r_pwm_p, r_pwm_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_dt_cnt <= '0;
      r_pwm_p  <= 1'b0;
      r_pwm_n  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dt_cnt <= w_dt_cnt_nxt;
      r_pwm_p  <= (w_state_nxt == ST_P_ON);
      r_pwm_n  <= (w_state_nxt == ST_N_ON);
    end
  end

  // The dead counter is cleared outside DEAD so every gap starts from zero.
  always_comb begin
    w_state_nxt  = r_state;
    w_dt_cnt_nxt = '0;
    case (r_state)
      ST_IDLE: if (i_cnt_zero) w_state_nxt = ST_DEAD;
      ST_P_ON: if (!i_raw) w_state_nxt = ST_DEAD;
      ST_N_ON: if (i_raw) w_state_nxt = ST_DEAD;
      ST_DEAD: begin
        if (r_dt_cnt == DT_LAST) w_state_nxt = i_raw ? ST_P_ON : ST_N_ON;
        else w_dt_cnt_nxt = r_dt_cnt + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_pwm_p = r_pwm_p;
  assign o_pwm_n = r_pwm_n;

endmodule

// File: rtl/pwm_modulator_aw.sv
// rtl/pwm_modulator_aw.sv - clamped PI command to double-buffered complementary PWM with anti-windup excess
// Optional dead-time gate FSM selected by DEADTIME_EN.
module pwm_modulator_aw
  import ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PERIOD   = 1000,
  parameter int DUTY_MIN = 50,
  parameter int DUTY_MAX = 950,
  parameter int DT       = 20,
  parameter int SHIFT    = 0
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic signed [CMD_W-1:0] i_U,
  output logic signed [CMD_W-1:0] o_AW,
  output logic                    o_PWM_P,
  output logic                    o_PWM_N,
  output logic                    o_SYNC,
  output logic [CNT_W-1:0]        o_DUTY
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_MIN_C = CNT_W'(DUTY_MIN);

  if (!(DT < DUTY_MIN && DT < PERIOD - DUTY_MAX && DUTY_MIN > 0 && DUTY_MIN <= DUTY_MAX &&
        DUTY_MAX < PERIOD && CNT_W <= CMD_W &&
        longint'(PERIOD) <= (longint'(1) << CNT_W))) begin : g_param_check
    $error("pwm_modulator_aw: illegal parameter set");
  end

  logic [CNT_W-1:0]        r_cnt, r_shadow, r_active;
  logic signed [CMD_W-1:0] r_aw;
  logic                    r_sync;
  logic                    w_cnt_zero, w_cnt_last, w_raw;
  logic signed [CMD_W-1:0] w_u_s, w_sat, w_aw;
  logic signed [CMD_W:0]   w_diff;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_raw      = (r_cnt < r_active);

  assign w_u_s  = i_U >>> SHIFT;
  assign w_sat  = clamp_s(w_u_s, CMD_W'(DUTY_MIN), CMD_W'(DUTY_MAX));
  assign w_diff = {w_u_s[CMD_W-1], w_u_s} - {w_sat[CMD_W-1], w_sat};

  // Excess is formed one bit wider, then pinned to the 32-bit range on overflow.
  always_comb begin
    w_aw = w_diff[CMD_W-1:0];
    if (w_diff[CMD_W] != w_diff[CMD_W-1])
      w_aw = w_diff[CMD_W] ? {1'b1, {(CMD_W-1){1'b0}}} : {1'b0, {(CMD_W-1){1'b1}}};
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_cnt    <= '0;
      r_shadow <= DUTY_MIN_C;
      r_active <= DUTY_MIN_C;
      r_aw     <= '0;
      r_sync   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_last ? '0 : r_cnt + 1'b1;
      r_sync   <= w_cnt_zero;
      r_shadow <= w_sat[CNT_W-1:0];
      r_aw     <= w_aw;
      if (w_cnt_last) r_active <= r_shadow;
    end
  end

`ifdef DEADTIME_EN
  deadtime_gen #(
    .CNT_W (CNT_W),
    .DT    (DT)
  ) u_deadtime_gen (
    .i_clk      (i_CLK),
    .i_rst      (i_RST),
    .i_cnt_zero (w_cnt_zero),
    .i_raw      (w_raw),
    .o_pwm_p    (o_PWM_P),
    .o_pwm_n    (o_PWM_N)
  );
`else
  logic r_run, r_pwm_p, r_pwm_n;
  logic w_gate_en;

  // Gates stay off until the carrier has been seen at zero once.
  assign w_gate_en = r_run | w_cnt_zero;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_run   <= 1'b0;
      r_pwm_p <= 1'b0;
      r_pwm_n <= 1'b0;
    end else begin
      r_run   <= w_gate_en;
      r_pwm_p <= w_raw & w_gate_en;
      r_pwm_n <= ~w_raw & w_gate_en;
    end
  end

  assign o_PWM_P = r_pwm_p;
  assign o_PWM_N = r_pwm_n;
`endif

  assign o_AW   = r_aw;
  assign o_SYNC = r_sync;
  assign o_DUTY = r_active;

endmodule

// File: tb/tb_pwm_modulator_aw.sv
// tb/tb_pwm_modulator_aw.sv - directed self-checking bench for pwm_modulator_aw (either DEADTIME_EN build)
module tb_pwm_modulator_aw;

`ifdef DEADTIME_EN
  localparam int EXP_P_HI = 480, EXP_N_HI = 480, EXP_P_RISE = 21, EXP_N_RISE = 521, EXP_P_CNT1 = 0;
`else
  localparam int EXP_P_HI = 500, EXP_N_HI = 500, EXP_P_RISE = 1, EXP_N_RISE = 501, EXP_P_CNT1 = 1;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] u, u2;
  logic signed [31:0] aw, aw2;
  logic               p, n, sync, p2, n2, sync2;
  logic [15:0]        duty, duty2;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cnt   = 0;

  always #5 clk = ~clk;

  pwm_modulator_aw u_dut (
    .i_CLK(clk), .i_RST(rst), .i_U(u), .o_AW(aw),
    .o_PWM_P(p), .o_PWM_N(n), .o_SYNC(sync), .o_DUTY(duty)
  );

  pwm_modulator_aw #(.SHIFT(2)) u_dut2 (
    .i_CLK(clk), .i_RST(rst), .i_U(u2), .o_AW(aw2),
    .o_PWM_P(p2), .o_PWM_N(n2), .o_SYNC(sync2), .o_DUTY(duty2)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tb_cnt = (tb_cnt + 1) % 1000;
  endtask

  task automatic run_to(input int target);
    do cyc(); while (tb_cnt != target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hp, hn, both, nsync, sync_at, p_rise, p_fall, n_rise, n_fall;
    logic prev_p, prev_n;

    rst = 1'b1; u = 32'sd500; u2 = 32'sd0;
    cyc(); cyc(); cyc();
    chk("rst_p", p, 0);
    chk("rst_n", n, 0);
    chk("rst_sync", sync, 0);
    chk("rst_aw", aw, 0);
    chk("rst_duty", duty, 50);
    chk("rst_duty2", duty2, 50);
    chk("rst_p2n2", {p2, n2}, 0);

    rst = 1'b0; tb_cnt = 0;
    cyc();
    chk("first_sync", sync, 1);
    chk("first_sync2", sync2, 1);
    chk("first_p", p, EXP_P_CNT1);
    chk("first_n", n, 0);
    chk("first_aw", aw, 0);

    run_to(0);
    chk("duty_500", duty, 500);

    prev_p = p; prev_n = n;
    hp = 0; hn = 0; both = 0; nsync = 0; sync_at = -1;
    p_rise = -1; p_fall = -1; n_rise = -1; n_fall = -1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (p) hp++;
      if (n) hn++;
      if (p && n) both++;
      if (sync) begin nsync++; sync_at = tb_cnt; end
      if (p && !prev_p) p_rise = tb_cnt;
      if (!p && prev_p) p_fall = tb_cnt;
      if (n && !prev_n) n_rise = tb_cnt;
      if (!n && prev_n) n_fall = tb_cnt;
      prev_p = p; prev_n = n;
    end
    chk("p_high_cycles", hp, EXP_P_HI);
    chk("n_high_cycles", hn, EXP_N_HI);
    chk("p_and_n", both, 0);
    chk("sync_count", nsync, 1);
    chk("sync_pos", sync_at, 1);
    chk("p_rise_cnt", p_rise, EXP_P_RISE);
    chk("p_fall_cnt", p_fall, 501);
    chk("n_rise_cnt", n_rise, EXP_N_RISE);
    chk("n_fall_cnt", n_fall, 1);

    u = 32'sd2000;
    cyc();
    chk("aw_hi", aw, 1050);
    chk("duty_hold", duty, 500);
    run_to(0);
    chk("duty_max", duty, 950);

    u = -32'sd100;
    cyc();
    chk("aw_lo", aw, -150);
    run_to(0);
    chk("duty_min", duty, 50);

    u = 32'sh8000_0000;
    cyc();
    chk("aw_sat", aw, -64'sd2147483648);

    u = 32'sd300;
    run_to(0);
    chk("duty_300", duty, 300);
    run_to(400);
    u = 32'sd700;
    cyc();
    chk("mid_period_hold", duty, 300);
    run_to(999);
    chk("end_period_hold", duty, 300);
    cyc();
    chk("duty_700", duty, 700);
    run_to(999);
    u = 32'sd100;
    cyc();
    chk("late_change_ignored", duty, 700);
    run_to(0);
    chk("duty_100", duty, 100);

    u = 32'sd2000;
    run_to(0);
    run_to(600);
    chk("pre_rst_p", p, 1);
    chk("pre_rst_aw", aw, 1050);
    #2;
    rst = 1'b1;
    #1;
    chk("async_p", p, 0);
    chk("async_n", n, 0);
    chk("async_aw", aw, 0);
    chk("async_sync", sync, 0);
    cyc(); cyc();
    rst = 1'b0; tb_cnt = 0; u = 32'sd500;
    chk("post_rst_duty", duty, 50);
    cyc();
    chk("post_rst_sync", sync, 1);

    u2 = 32'sd2000;
    cyc();
    chk("shift_aw", aw2, 0);
    run_to(0);
    chk("shift_duty", duty2, 500);
    u2 = -32'sd3;
    cyc();
    chk("shift_neg_aw", aw2, -51);
    run_to(0);
    chk("shift_neg_duty", duty2, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
